// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: segment state encoding, per-stage payload
// widths and field offsets used to pack/unpack the inter-stage buses.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    SEG_EMPTY = 2'd0,
    SEG_FULL  = 2'd1,
    SEG_SKID  = 2'd2
  } seg_state_e;

  localparam int FIELD_W  = 32;
  localparam int PC_OFF   = 0;
  localparam int INST_OFF = 32;
  localparam int RES_OFF  = 64;
  localparam int HI_OFF   = 96;
  localparam int LO_OFF   = 128;
  localparam int CTRL_OFF = 160;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 192;
  localparam int EXMEM_W = 192;
  localparam int MEMWB_W = 192;

  function automatic logic [FIELD_W-1:0] get_field(input logic [MEMWB_W-1:0] bus,
                                                   input int off);
    return bus[off +: FIELD_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with valid/ready handshake, synchronous flush,
// optional skid entry (registered in_ready) and a saturating stall counter.
module pipe_seg_skid
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 192,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  seg_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire, stall_inc;

  assign out_valid = (state_q != SEG_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // With the skid entry, ready depends only on state; without it, ready
  // looks through to out_ready so a full main entry can be replaced in place.
  always_comb begin
    if (reset) begin
      in_ready = 1'b0;
    end else if (SKID != 0) begin
      in_ready = (state_q != SEG_SKID);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SEG_EMPTY: begin
        if (in_fire) begin
          state_d = SEG_FULL;
          main_d  = in_data;
        end
      end
      SEG_FULL: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire && (SKID != 0)) begin
          state_d = SEG_SKID;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = SEG_EMPTY;
        end
      end
      SEG_SKID: begin
        if (out_fire) begin
          state_d = SEG_FULL;
          main_d  = skid_q;
        end
      end
      default: state_d = SEG_EMPTY;
    endcase
    // Flush drops validity only; payload registers are left untouched.
    if (flush) begin
      state_d = SEG_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEG_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Bench for pipe_seg_skid: table-driven streaming/backpressure vectors,
// hand-written flush/reset/SKID=0/saturation sequences and an ordering scoreboard.
module tb_pipe_seg_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_ir, a_ov, b_ir, b_ov, c_ir, c_ov;
  logic [31:0] a_od, b_od, c_od;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [15:0] a_st, b_st;
  logic [3:0]  c_st;

  logic        cur_ir, cur_ov;
  logic [31:0] cur_od;
  logic [1:0]  cur_occ;
  logic [15:0] cur_st;
  int          sel = 0;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pipe_seg_skid #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .occupancy(a_occ), .stall_cnt(a_st));

  pipe_seg_skid #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .occupancy(b_occ), .stall_cnt(b_st));

  pipe_seg_skid #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ir),
    .in_data(in_data), .out_valid(c_ov), .out_ready(out_ready), .out_data(c_od),
    .occupancy(c_occ), .stall_cnt(c_st));

  always_comb begin
    cur_ir = a_ir; cur_ov = a_ov; cur_od = a_od; cur_occ = a_occ; cur_st = a_st;
    if (sel == 1) begin
      cur_ir = b_ir; cur_ov = b_ov; cur_od = b_od; cur_occ = b_occ; cur_st = b_st;
    end else if (sel == 2) begin
      cur_ir = c_ir; cur_ov = c_ov; cur_od = c_od; cur_occ = c_occ; cur_st = {12'd0, c_st};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: held entries in FIFO order; flush discards whatever remains.
  always @(negedge clk) begin
    if (!rst) begin
      if (cur_ov && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", cur_od, 32'hFFFF_FFFF);
        end else begin
          check("sb_order", cur_od, sb.pop_front());
        end
      end
      if (flush) sb.delete();
      else if (in_valid && cur_ir) sb.push_back(in_data);
    end
  end

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(negedge clk);
  endtask

  task automatic do_reset(input int new_sel);
    @(negedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    sb.delete();
    @(negedge clk);
    #2;
    sel = new_sel;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic [31:0] e_od;
    logic [15:0] e_st;
  } vec_t;

  vec_t vt[14];

  initial begin
    #400_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int occ_m;
    logic exp_ir, ordy;

    // Streaming (rows 0-5) then backpressure with A, B, C (rows 6-13).
    vt[0]  = '{1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0, 16'd0};
    vt[1]  = '{1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 2'd1, 32'h1, 16'd0};
    vt[2]  = '{1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 2'd1, 32'h2, 16'd0};
    vt[3]  = '{1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 2'd1, 32'h3, 16'd0};
    vt[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h4, 16'd0};
    vt[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h4, 16'd0};
    vt[6]  = '{1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 2'd0, 32'h4, 16'd0};
    vt[7]  = '{1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 2'd1, 32'hA, 16'd0};
    vt[8]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA, 16'd1};
    vt[9]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 2'd2, 32'hA, 16'd2};
    vt[10] = '{1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 2'd2, 32'hA, 16'd3};
    vt[11] = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 2'd1, 32'hB, 16'd3};
    vt[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'hC, 16'd3};
    vt[13] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'hC, 16'd3};

    // Reset state
    #3;
    check("rst_in_ready", {31'd0, a_ir}, 32'd0);
    check("rst_out_valid", {31'd0, a_ov}, 32'd0);
    check("rst_occ", {30'd0, a_occ}, 32'd0);
    check("rst_out_data", a_od, 32'd0);
    check("rst_stall", {16'd0, a_st}, 32'd0);
    do_reset(0);

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].iv, vt[i].d, vt[i].ordy, 1'b0);
      check($sformatf("vec%0d_in_ready", i), {31'd0, cur_ir}, {31'd0, vt[i].e_ir});
      check($sformatf("vec%0d_out_valid", i), {31'd0, cur_ov}, {31'd0, vt[i].e_ov});
      check($sformatf("vec%0d_occ", i), {30'd0, cur_occ}, {30'd0, vt[i].e_occ});
      check($sformatf("vec%0d_out_data", i), cur_od, vt[i].e_od);
      check($sformatf("vec%0d_stall", i), {16'd0, cur_st}, {16'd0, vt[i].e_st});
    end

    // Flush from SKID state with 0xDEAD offered
    do_reset(0);
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1);
    check("fl_pre_occ", {30'd0, cur_occ}, 32'd2);
    check("fl_pre_ir", {31'd0, cur_ir}, 32'd0);
    drive(1'b1, 32'h5, 1'b1, 1'b0);
    check("fl_post_occ", {30'd0, cur_occ}, 32'd0);
    check("fl_post_ov", {31'd0, cur_ov}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_next_ov", {31'd0, cur_ov}, 32'd1);
    check("fl_next_data", cur_od, 32'h5);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_alone_ov", {31'd0, cur_ov}, 32'd0);
    // Flush drops a same-cycle accepted input; payload register keeps 0x5
    drive(1'b1, 32'h66, 1'b1, 1'b1);
    check("fl_drop_ir", {31'd0, cur_ir}, 32'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_drop_occ", {30'd0, cur_occ}, 32'd0);
    check("fl_drop_data", cur_od, 32'h5);
    // Flush with same-cycle out_fire: 0x77 consumed, then empty
    drive(1'b1, 32'h77, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("fl_cons_data", cur_od, 32'h77);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("fl_cons_occ", {30'd0, cur_occ}, 32'd0);

    // Asynchronous reset at occupancy 2
    do_reset(0);
    drive(1'b1, 32'h31, 1'b0, 1'b0);
    drive(1'b1, 32'h32, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("ar_pre_occ", {30'd0, cur_occ}, 32'd2);
    check("ar_pre_stall", {16'd0, cur_st}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ov", {31'd0, cur_ov}, 32'd0);
    check("ar_ir", {31'd0, cur_ir}, 32'd0);
    check("ar_stall", {16'd0, cur_st}, 32'd0);
    check("ar_data", cur_od, 32'd0);
    check("ar_occ", {30'd0, cur_occ}, 32'd0);
    sb.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_rel_ir", {31'd0, cur_ir}, 32'd1);
    drive(1'b1, 32'h7, 1'b1, 1'b0);
    check("ar_first_ov_pre", {31'd0, cur_ov}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("ar_first_ov", {31'd0, cur_ov}, 32'd1);
    check("ar_first_data", cur_od, 32'h7);

    // SKID=0: toggling out_ready under continuous input
    do_reset(1);
    occ_m = 0;
    for (int i = 0; i < 8; i++) begin
      ordy = (i % 2 == 0);
      drive(1'b1, 32'h100 + i, ordy, 1'b0);
      exp_ir = (occ_m == 0) || ordy;
      check($sformatf("s0_ir%0d", i), {31'd0, cur_ir}, {31'd0, exp_ir});
      check($sformatf("s0_occ%0d", i), {30'd0, cur_occ}, occ_m);
      if (exp_ir) occ_m = 1;
      else if (occ_m == 1 && ordy) occ_m = 0;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("s0_drained_occ", {30'd0, cur_occ}, 32'd0);

    // Stall counter saturation (CNT_W=4)
    do_reset(2);
    drive(1'b1, 32'h9, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check($sformatf("sat_k%0d", k), {16'd0, cur_st}, (k - 1 > 15) ? 32'd15 : k - 1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("sat_hold", {16'd0, cur_st}, 32'd15);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("sat_after", {16'd0, cur_st}, 32'd15);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_seg_skid.md
Name: pipe_seg_skid

Overview:
- Parametrised pipeline segment register with a valid/ready handshake.
- Replaces the fixed, always-advancing stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) between pipeline stages.
- Adds backpressure, a synchronous flush, an optional 2-entry skid buffer so that in_ready is registered, and a saturating stall counter.
- Each stage instantiates it with its own packed payload width.

Parameters:
- DATA_W, 192: packed payload width in bits (pc, inst, res, hi, lo, control bits).
- SKID, 1: 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held and incoming entries (exception/branch redirect).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  segment accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a valid payload.
- out_ready  in  1  downstream consumes the payload this cycle.
- out_data  out  DATA_W  main entry payload.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (asynchronous, immediate):
  - state = EMPTY; out_valid = 0; occupancy = 0; stall_cnt = 0.
  - main and skid data = 0, so out_data = 0.
  - in_ready is forced to 0 while reset is high.
- States: EMPTY (occupancy 0), FULL (occupancy 1, main valid), SKID (occupancy 2, main + skid valid; only reachable when SKID=1).
- in_ready:
  - SKID=1: in_ready = (state != SKID), a pure register decode.
  - SKID=0: in_ready = !out_valid | out_ready (combinational).
- Transitions (flush = 0):
  - EMPTY: in_fire -> FULL, main <= in_data.
  - FULL: in_fire & out_fire -> FULL, main <= in_data.
  - FULL: in_fire & !out_fire -> SKID, skid <= in_data (SKID=1 only; with SKID=0 this case cannot occur).
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: neither fires -> hold.
  - SKID: out_fire -> FULL, main <= skid. No input is accepted in this state.
  - SKID: !out_fire -> hold.
- Flush:
  - Highest priority below reset. Next state = EMPTY regardless of in_fire or out_fire.
  - A same-cycle in_fire is accepted upstream but dropped.
  - A same-cycle out_fire still counts as consumed downstream.
  - Data registers keep their values; only valid state clears.
- Latency: 1 cycle from in_fire to out_valid. Throughput is 1 per cycle with out_ready held high.
- Ordering: strict FIFO; no loss, duplication or reordering without flush.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change (flush excepted).
- occupancy: registered, equal to the state encoding.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready, including the flush cycle.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Payload is opaque: no width conversion; in_data passes bit-exact to out_data.

Decomposition:
- Shared package (cpu_pipe_pkg):
  - state encoding constants: SEG_EMPTY=2'd0, SEG_FULL=2'd1, SEG_SKID=2'd2;
  - per-stage payload widths: EXMEM_W etc.;
  - field offset constants used to pack and unpack stage buses.
- Sub-module sat_counter (width CNT_W, inc, async reset) for stall_cnt.
- Data path and state machine stay in pipe_seg_skid.

Test Plan:
- Streaming, SKID=1, DATA_W=32: in_valid=1 with data 0x1,0x2,0x3,0x4 on consecutive cycles, out_ready=1 -> out_data 0x1..0x4 each one cycle later, in_ready stays 1, occupancy stays 1, stall_cnt=0.
- Backpressure: send 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream. Release out_ready -> outputs 0xA,0xB,0xC in order; stall_cnt equals the number of blocked cycles.
- Flush while in SKID state with in_valid=1 (data 0xDEAD) -> next cycle occupancy=0, out_valid=0, 0xDEAD never appears on out_data. Next input 0x5 emerges alone.
- SKID=0 variant: out_ready toggling 1,0,1,0 under continuous input -> in_ready equals !out_valid|out_ready each cycle, occupancy never exceeds 1, order preserved.
- Reset asserted mid-operation at occupancy=2, asynchronous to clk -> out_valid=0, in_ready=0, stall_cnt=0 and out_data=0 immediately. After release, in_ready=1 and the first input 0x7 appears one cycle after acceptance.
- Saturation, CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
